// File: rtl/reload_counter.sv
// Up/down counter with load/reload value, terminal wrap pulse and
// optional one-shot halt.
module reload_counter #(
    parameter int WIDTH    = 4,
    parameter int ONE_SHOT = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic [WIDTH-1:0] reload_o,
    output logic             wrap_o,
    output logic             done_o
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             wrap_q, wrap_d;
    logic             at_term;

    // Terminal follows the direction sampled this cycle.
    assign at_term = dir_i ? (&count_q) : ~(|count_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RUN;
            count_q  <= '0;
            reload_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            wrap_q   <= wrap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        wrap_d   = 1'b0;
        if (load_i) begin
            count_d  = load_val_i;
            reload_d = load_val_i;
            state_d  = RUN;
        end else if (state_q == HALT) begin
            count_d = count_q;
        end else if (en_i) begin
            if (at_term) begin
                wrap_d = 1'b1;
                if (ONE_SHOT != 0) begin
                    state_d = HALT;
                end else begin
                    count_d = reload_q;
                end
            end else if (dir_i) begin
                count_d = count_q + WIDTH'(1);
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    assign count_o  = count_q;
    assign reload_o = reload_q;
    assign wrap_o   = wrap_q;
    assign done_o   = (ONE_SHOT != 0) && (state_q == HALT);

endmodule
